// File: rtl/sig_meter.sv
`timescale 1ns/1ps
// sig_meter: measures rising-to-rising period, high time or low time of an
// asynchronous input, averaged over 2^k intervals at TICK_HZ resolution.
// Saturates (all ones + overflow) instead of wrapping; times out if the input
// stops toggling.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start             start request (accepted only when o_ready=1)
//   i_mode              00 period, 01 high, 10 low, 11 period
//   i_avg_log2          averaging exponent k (clamped to MAX_AVG_LOG2)
//   i_signal            asynchronous signal under measurement
//   o_ready             idle indicator (combinational from state)
//   o_done              one-cycle pulse when o_result/o_overflow update
//   o_overflow          last measurement saturated or timed out
//   o_result            average interval in ticks
module sig_meter #(
    parameter int unsigned CLK_FREQ     = 100_000_000,
    parameter int unsigned TICK_HZ      = 1_000_000,
    parameter int unsigned W            = 20,
    parameter int unsigned MAX_AVG_LOG2 = 3
) (
    input  logic                                  i_clk,
    input  logic                                  i_rst,
    input  logic                                  i_start,
    input  logic [1:0]                            i_mode,
    input  logic [$clog2(MAX_AVG_LOG2+1)-1:0]     i_avg_log2,
    input  logic                                  i_signal,
    output logic                                  o_ready,
    output logic                                  o_done,
    output logic                                  o_overflow,
    output logic [W-1:0]                          o_result
);

    localparam int unsigned DIV = CLK_FREQ / TICK_HZ;
    localparam int unsigned PW  = $clog2(DIV);
    localparam int unsigned AW  = W + MAX_AVG_LOG2;
    localparam int unsigned KW  = $clog2(MAX_AVG_LOG2 + 1);
    localparam int unsigned CW  = MAX_AVG_LOG2 + 1;

    localparam logic [1:0] M_PERIOD = 2'b00;
    localparam logic [1:0] M_HIGH   = 2'b01;
    localparam logic [1:0] M_LOW    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_MEASURE,
        S_GAP,
        S_DONE
    } state_t;

    state_t state_q, state_d;

    logic          sync_q1, sync_q2, sig_prev;
    logic [PW-1:0] pre;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [W-1:0]  tmo;
    logic [1:0]    mode_q;
    logic [KW-1:0] k_q;

    logic          rise, fall, tick;
    logic          start_edge, stop_edge;
    logic [AW:0]   acc_sum, acc_limit;
    logic          sat_hit, tmo_hit, last_interval;
    logic [KW-1:0] k_in;

    // Control strobes from the FSM
    logic start_acc, pre_clr, acc_inc, cnt_inc, tmo_clr, tmo_inc, finish, ovf_set;

    // Edge pulses from the synchronised signal and its delayed copy
    assign rise = sync_q2 & ~sig_prev;
    assign fall = ~sync_q2 & sig_prev;
    assign tick = (pre == PW'(DIV - 1));

    assign start_edge = (mode_q == M_LOW)  ? fall : rise;
    assign stop_edge  = (mode_q == M_HIGH) ? fall : rise;

    // acc_sum includes a tick coinciding with the current cycle
    assign acc_sum       = {1'b0, acc} + (AW+1)'(tick);
    assign acc_limit     = (AW+1)'(1) << (W + 32'(k_q));
    assign sat_hit       = tick && (acc_sum >= acc_limit);
    // Next tick brings the timeout count to 2^W-1
    assign tmo_hit       = tick && (tmo == ~W'(1));
    assign last_interval = ((cnt + CW'(1)) == (CW'(1) << k_q));

    assign k_in = (i_avg_log2 > KW'(MAX_AVG_LOG2)) ? KW'(MAX_AVG_LOG2) : i_avg_log2;

    assign o_ready = (state_q == S_IDLE);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_rst) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next-state and control strobes
    always_comb begin
        state_d   = state_q;
        start_acc = 1'b0;
        pre_clr   = 1'b0;
        acc_inc   = 1'b0;
        cnt_inc   = 1'b0;
        tmo_clr   = 1'b0;
        tmo_inc   = 1'b0;
        finish    = 1'b0;
        ovf_set   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    start_acc = 1'b1;
                    state_d   = S_ARM;
                end
            end
            S_ARM, S_GAP: begin
                tmo_inc = tick;
                if (start_edge) begin
                    pre_clr = 1'b1;
                    state_d = S_MEASURE;
                end else if (tmo_hit) begin
                    finish  = 1'b1;
                    ovf_set = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_MEASURE: begin
                // Saturation takes priority over a coincident final stop edge
                if (sat_hit) begin
                    finish  = 1'b1;
                    ovf_set = 1'b1;
                    state_d = S_DONE;
                end else begin
                    acc_inc = tick;
                    if (stop_edge) begin
                        cnt_inc = 1'b1;
                        if (last_interval) begin
                            finish  = 1'b1;
                            state_d = S_DONE;
                        end else if (mode_q != M_PERIOD) begin
                            // Period intervals are contiguous; high/low wait for next start edge
                            tmo_clr = 1'b1;
                            state_d = S_GAP;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Datapath: synchroniser, prescaler, counters and result registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            sync_q1    <= 1'b0;
            sync_q2    <= 1'b0;
            sig_prev   <= 1'b0;
            pre        <= '0;
            acc        <= '0;
            cnt        <= '0;
            tmo        <= '0;
            mode_q     <= M_PERIOD;
            k_q        <= '0;
            o_done     <= 1'b0;
            o_overflow <= 1'b0;
            o_result   <= '0;
        end else begin
            sync_q1  <= i_signal;
            sync_q2  <= sync_q1;
            sig_prev <= sync_q2;

            if (pre_clr || state_q == S_IDLE) pre <= '0;
            else if (tick)                    pre <= '0;
            else                              pre <= pre + PW'(1);

            if (start_acc) begin
                mode_q <= (i_mode == 2'b11) ? M_PERIOD : i_mode;
                k_q    <= k_in;
                acc    <= '0;
                cnt    <= '0;
            end else begin
                if (acc_inc) acc <= acc_sum[AW-1:0];
                if (cnt_inc) cnt <= cnt + CW'(1);
            end

            if (start_acc || tmo_clr) tmo <= '0;
            else if (tmo_inc)         tmo <= tmo + W'(1);

            o_done <= finish;
            if (finish) begin
                o_overflow <= ovf_set;
                o_result   <= ovf_set ? '1 : W'(acc_sum >> k_q);
            end
        end
    end

endmodule

// File: tb/tb_sig_meter.sv
`timescale 1ns/1ps
module tb_sig_meter;

    localparam int unsigned W  = 8;
    localparam int unsigned KW = 2;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    mode;
    logic [KW-1:0] k;
    logic          sig;
    logic          ready;
    logic          done;
    logic          ovf;
    logic [W-1:0]  result;

    sig_meter #(
        .CLK_FREQ    (1000),
        .TICK_HZ     (100),
        .W           (W),
        .MAX_AVG_LOG2(3)
    ) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_mode     (mode),
        .i_avg_log2 (k),
        .i_signal   (sig),
        .o_ready    (ready),
        .o_done     (done),
        .o_overflow (ovf),
        .o_result   (result)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [1:0]   mode;
        logic [1:0]   k;
        int           lo_a;
        int           hi_a;
        int           lo_b;
        int           hi_b;
        logic [W-1:0] exp_res;
        logic         exp_ovf;
    } vec_t;

    typedef struct {
        logic [W-1:0] res;
        logic         ovf;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Pattern generator: low lo_a, high hi_a, low lo_b, high hi_b, repeating
    bit gen_en = 1'b0;
    int lo_a = 1, hi_a = 1, lo_b = 1, hi_b = 1;
    int gpos = 0;
    initial begin
        sig = 1'b0;
        forever begin
            @(negedge clk);
            if (!gen_en) begin
                sig  = 1'b0;
                gpos = 0;
            end else begin
                if (gpos < lo_a)                    sig = 1'b0;
                else if (gpos < lo_a + hi_a)        sig = 1'b1;
                else if (gpos < lo_a + hi_a + lo_b) sig = 1'b0;
                else                                sig = 1'b1;
                gpos = (gpos + 1) % (lo_a + hi_a + lo_b + hi_b);
            end
        end
    end

    // Scoreboard consumer: every o_done pops one expected result
    initial begin
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_done: o_done=1 result=%0d with nothing expected", result);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    check("result", 32'(result), 32'(e.res));
                    check("overflow", 32'(ovf), 32'(e.ovf));
                end
            end
        end
    end

    // Waits for o_done, then checks the one-cycle pulse and that a start in DONE is dropped
    task automatic wait_done(input int budget, input string name);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL %s_timeout: no o_done within %0d cycles", name, budget);
        end else begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            check({name, "_ready_after_done"}, 32'(ready), 32'd1);
            check({name, "_done_width"}, 32'(done), 32'd0);
            @(negedge clk);
            check({name, "_start_in_done_ignored"}, 32'(ready), 32'd1);
        end
    endtask

    task automatic launch(input vec_t v, input string name);
        lo_a   = v.lo_a;
        hi_a   = v.hi_a;
        lo_b   = v.lo_b;
        hi_b   = v.hi_b;
        gen_en = (v.hi_a != 0);
        mode   = v.mode;
        k      = v.k;
        repeat (2) @(negedge clk);
        check({name, "_ready_idle"}, 32'(ready), 32'd1);
        sb.push_back('{v.exp_res, v.exp_ovf});
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({name, "_ready_low_after_start"}, 32'(ready), 32'd0);
    endtask

    task automatic finish_gen();
        gen_en = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    vec_t vecs[7];
    vec_t v250;

    initial begin
        vecs[0] = '{2'b00, 2'd0, 125, 125, 125, 125, 8'd25, 1'b0};   // period 250
        vecs[1] = '{2'b01, 2'd2, 60, 40, 60, 40, 8'd4, 1'b0};        // high 40, avg 4
        vecs[2] = '{2'b10, 2'd0, 73, 50, 73, 50, 8'd7, 1'b0};        // low 73, truncation
        vecs[3] = '{2'b00, 2'd3, 150, 100, 100, 150, 8'd25, 1'b0};   // periods 200/300, avg 8
        vecs[4] = '{2'b11, 2'd1, 125, 125, 125, 125, 8'd25, 1'b0};   // mode 11 acts as period
        vecs[5] = '{2'b00, 2'd0, 1500, 1500, 1500, 1500, 8'hFF, 1'b1}; // saturation
        vecs[6] = '{2'b00, 2'd0, 0, 0, 0, 0, 8'hFF, 1'b1};           // constant low: timeout
        v250    = vecs[0];

        rst   = 1'b1;
        start = 1'b0;
        mode  = 2'b00;
        k     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        check("reset_ready", 32'(ready), 32'd1);
        check("reset_done", 32'(done), 32'd0);
        check("reset_overflow", 32'(ovf), 32'd0);
        check("reset_result", 32'(result), 32'd0);

        for (int i = 0; i < 7; i++) begin
            launch(vecs[i], $sformatf("vec%0d", i));
            wait_done(10000, $sformatf("vec%0d", i));
            finish_gen();
        end

        // Start pulse while measuring (k=2 keeps it busy) must be ignored
        v250.k = 2'd2;
        launch(v250, "busy");
        repeat (400) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("busy_still_measuring", 32'(ready), 32'd0);
        wait_done(10000, "busy");
        repeat (300) @(negedge clk);
        finish_gen();

        // Reset in the middle of a measurement: no o_done, outputs cleared
        v250.k = 2'd0;
        launch(v250, "rstmid");
        repeat (150) @(negedge clk);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rstmid_ready", 32'(ready), 32'd1);
        check("rstmid_done", 32'(done), 32'd0);
        check("rstmid_result", 32'(result), 32'd0);
        check("rstmid_overflow", 32'(ovf), 32'd0);
        gen_en = 1'b0;
        repeat (500) @(negedge clk);

        // Fresh measurement after the reset
        launch(v250, "fresh");
        wait_done(10000, "fresh");
        finish_gen();

        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sig_meter.md
# sig_meter

Parametrised signal-timing meter; successor of the single-mode millisecond period counter. On request it measures one of three interval types on an asynchronous input: rising-to-rising period, high time or low time. It averages over 2^k intervals at a configurable tick resolution and saturates with an overflow flag instead of wrapping. It sits between a GPIO/sensor input and the display/UART formatting logic and uses the same ready/start/done handshake as the other measurement blocks.

## Interface
- `CLK_FREQ`, 100_000_000: system clock frequency in Hz.
- `TICK_HZ`, 1_000_000: measurement resolution in Hz. `DIV = CLK_FREQ/TICK_HZ` must be an integer ≥2.
- `W`, 20: result width in ticks.
- `MAX_AVG_LOG2`, 3: largest supported averaging exponent k.
- `i_clk` input 1: system clock; all logic on its rising edge.
- `i_rst` input 1: synchronous, active-high reset.
- `i_start` input 1: start request; sampled only in IDLE.
- `i_mode` input 2: 00 period, 01 high time, 10 low time, 11 treated as period. Latched at start.
- `i_avg_log2` input `$clog2(MAX_AVG_LOG2+1)`: k. Values >`MAX_AVG_LOG2` are clamped. Latched at start.
- `i_signal` input 1: asynchronous signal under measurement.
- `o_ready` output 1: high in IDLE (combinational from state).
- `o_done` output 1: one-cycle pulse when `o_result` and `o_overflow` update.
- `o_overflow` output 1: registered; set if the last measurement saturated or timed out.
- `o_result` output W: registered average interval in ticks; holds until the next `o_done`.

## Operation
- **Input conditioning**
  - `i_signal` passes through a 2-flop synchroniser, then a previous-value register; rise/fall pulses are derived from these.
  - This gives a fixed 3-cycle edge latency, which cancels out of every interval measurement.
- **Tick prescaler**
  - Counts 0..DIV-1 and emits a tick on wrap.
  - Period mode: cleared on the first rising edge, then free-running for the whole measurement.
  - High/low modes: cleared at each interval start edge.
  - A partial tick at an interval end is discarded (truncation).
- **Accumulator** (width W+MAX_AVG_LOG2)
  - Adds 1 per tick while in MEASURE.
  - Result = accumulator >> k (truncating).
- **Interval counter** counts completed intervals up to 2^k.
- **States**
  - IDLE: `o_ready`=1. On `i_start`: latch mode and k, clear accumulator, interval counter and timeout counter, go to ARM.
  - ARM: wait for the start edge (rise for period/high, fall for low). On the edge: clear prescaler, go to MEASURE.
  - MEASURE: count ticks. On the stop edge (period: rise; high: fall; low: rise), increment the interval counter.
    - If the count reaches 2^k, go to DONE.
    - Otherwise, period mode stays in MEASURE (the stop edge is the next start edge, so periods are contiguous) and high/low modes go to GAP.
  - GAP: counting paused. On the start edge: clear prescaler, return to MEASURE.
  - DONE: for one cycle, `o_done`=1, and `o_result`/`o_overflow` take their new values in the same cycle. Then go to IDLE.
- **Saturation**
  - If an accumulator increment would make the accumulator ≥ 2^(W+k), go to DONE with `o_result` = all ones and `o_overflow`=1.
- **Timeout**
  - In ARM and GAP, a separate W-bit tick counter runs (prescaler free-running). It is cleared on entry to ARM or GAP.
  - When it reaches 2^W−1 ticks, go to DONE with `o_result` = all ones and `o_overflow`=1.
- **Busy behaviour**: `i_start` outside IDLE is ignored; mode and k cannot change mid-measurement.

## Timing
- Reset (synchronous, `i_rst`=1 at a clock edge) forces IDLE and clears all counters and synchroniser flops.
- After reset: `o_ready`=1, `o_done`=0, `o_overflow`=0, `o_result`=0. Applies mid-measurement too; no `o_done` is issued.
- Start latency: `i_start` high at edge N → state ARM from edge N+1; `o_ready` low in that cycle.
- A pin edge at cycle t is acted on at cycle t+3.
- DONE is entered the cycle after the final stop edge is detected. `o_done` is exactly 1 cycle; `o_ready` returns the following cycle.
- Simultaneous tick and stop edge in MEASURE: the tick counts, then the interval closes.
- Simultaneous saturation and final stop edge: saturation wins.
- `i_start` asserted in the DONE cycle is ignored. It is accepted in IDLE one cycle later.

## Test plan
Sim overrides: `CLK_FREQ`=1000, `TICK_HZ`=100 (DIV=10), `W`=8, `MAX_AVG_LOG2`=3.
- Period mode, k=0, square wave with 250-clk period → one `o_done` pulse, `o_result`=25, `o_overflow`=0.
- High mode, k=2, pulses 40 clk high / 60 clk low → `o_result`=4. Low mode, k=0, 73-clk low phase → `o_result`=7 (truncation).
- Period mode, k=3, periods alternating 200/300 clk (2000 clk, 200 ticks total) → `o_result`=25.
- Period mode, k=0, 3000-clk period → saturation after 256 ticks: `o_result`=255, `o_overflow`=1. Constant-low `i_signal` → timeout after 255 ticks in ARM with the same outputs.
- `i_start` pulsed during MEASURE → ignored, result unchanged. `i_rst` asserted mid-MEASURE → next cycle IDLE, `o_ready`=1, `o_result`=0, no `o_done`. A fresh measurement then succeeds.
